// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct fields, ALU/immediate enums and decode helpers.
// Optional multiply support in the core is enabled with macro RISCV_MUL_EN.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // Sign-extended immediate for the given encoding format (opcode bits not needed).
  function automatic logic [XLEN-1:0] gen_imm(input logic [31:7] ins, input imm_fmt_e fmt);
    case (fmt)
      IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   return {ins[31:12], 12'b0};
      IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return {{20{ins[31]}}, ins[31:20]};
    endcase
  endfunction

  // Integer ALU op from funct3; alt selects SUB/SRA.
  function automatic alu_op_e alu_base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_pc.sv
// Program counter register with asynchronous reset to RESET_PC.
module riscv_core_pc
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] i_next_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= i_next_pc;
  end

  assign o_pc = pc;

endmodule

// File: rtl/riscv_core_regfile.sv
// Integer register file: two combinational read ports, one write port, x0 hardwired to zero.
module riscv_core_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_we,
  input  logic [XLEN-1:0] i_rd_data,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data
);

  logic [XLEN-1:0] r_regs [REG_COUNT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else if (i_rd_we && (i_rd_addr != 5'd0)) begin
      r_regs[i_rd_addr] <= i_rd_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_regs[i_rs2_addr];

endmodule

// File: rtl/riscv_core.sv
// Single-cycle RV32I core; combinational instruction memory, data memory written on clk.
// Define RISCV_MUL_EN to add MUL/MULH/MULHSU/MULHU.
module riscv_core
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] mem_read_data,
  output logic [XLEN-1:0] instr_addr,
  output logic [XLEN-1:0] data_addr,
  output logic            should_read_mem,
  output logic            should_write_mem,
  output logic [XLEN-1:0] mem_write_data
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu_res;
  logic [XLEN-1:0] w_rd_data;
  logic            w_reg_we;
  logic            w_a_pc;
  logic            w_a_zero;
  logic            w_b_imm;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_branch;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_br_taken;
  alu_op_e         w_alu_op;
  imm_fmt_e        w_imm_fmt;
  wb_sel_e         w_wb_sel;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_funct7 = instr[31:25];

  riscv_core_pc #(.RESET_PC(RESET_PC)) pc (
    .clk       (clk),
    .reset     (reset),
    .i_next_pc (w_next_pc),
    .o_pc      (w_pc)
  );

  riscv_core_regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .i_rd_addr  (w_rd),
    .i_rd_we    (w_reg_we),
    .i_rd_data  (w_rd_data),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data)
  );

  // Decoder: anything not matched below falls through as a NOP.
  always_comb begin
    w_reg_we    = 1'b0;
    w_alu_op    = ALU_ADD;
    w_imm_fmt   = IMM_I;
    w_wb_sel    = WB_ALU;
    w_a_pc      = 1'b0;
    w_a_zero    = 1'b0;
    w_b_imm     = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_reg_we  = 1'b1;
        w_imm_fmt = IMM_U;
        w_a_zero  = 1'b1;
        w_b_imm   = 1'b1;
      end
      OPC_AUIPC: begin
        w_reg_we  = 1'b1;
        w_imm_fmt = IMM_U;
        w_a_pc    = 1'b1;
        w_b_imm   = 1'b1;
      end
      OPC_JAL: begin
        w_reg_we  = 1'b1;
        w_imm_fmt = IMM_J;
        w_wb_sel  = WB_PC4;
        w_is_jal  = 1'b1;
      end
      OPC_JALR: begin
        w_reg_we  = 1'b1;
        w_wb_sel  = WB_PC4;
        w_is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm_fmt   = IMM_B;
        w_is_branch = 1'b1;
      end
      OPC_LOAD: begin
        w_reg_we  = 1'b1;
        w_wb_sel  = WB_MEM;
        w_is_load = 1'b1;
      end
      OPC_STORE: begin
        w_imm_fmt  = IMM_S;
        w_is_store = 1'b1;
      end
      OPC_OP_IMM: begin
        w_reg_we = 1'b1;
        w_b_imm  = 1'b1;
        w_alu_op = alu_base_op(w_funct3, (w_funct3 == F3_SR) && w_funct7[5]);
      end
      OPC_OP: begin
        if (w_funct7 == F7_BASE ||
            (w_funct7 == F7_ALT && (w_funct3 == F3_ADD || w_funct3 == F3_SR))) begin
          w_reg_we = 1'b1;
          w_alu_op = alu_base_op(w_funct3, w_funct7[5]);
        end
`ifdef RISCV_MUL_EN
        else if (w_funct7 == F7_MULDIV && !w_funct3[2]) begin
          w_reg_we = 1'b1;
          case (w_funct3[1:0])
            2'b00:   w_alu_op = ALU_MUL;
            2'b01:   w_alu_op = ALU_MULH;
            2'b10:   w_alu_op = ALU_MULHSU;
            default: w_alu_op = ALU_MULHU;
          endcase
        end
`endif
      end
      default: ;
    endcase
  end

  assign w_imm  = gen_imm(instr[31:7], w_imm_fmt);
  assign w_op_a = w_a_zero ? '0 : (w_a_pc ? w_pc : w_rs1_data);
  assign w_op_b = w_b_imm ? w_imm : w_rs2_data;

`ifdef RISCV_MUL_EN
  logic            w_a_signed;
  logic            w_b_signed;
  logic [63:0]     w_prod;
  // Low 64 bits of the product of sign/zero-extended operands cover all MUL variants.
  assign w_a_signed = (w_alu_op == ALU_MULH) || (w_alu_op == ALU_MULHSU);
  assign w_b_signed = (w_alu_op == ALU_MULH);
  assign w_prod = {{32{w_a_signed & w_op_a[31]}}, w_op_a} *
                  {{32{w_b_signed & w_op_b[31]}}, w_op_b};
`endif

  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_ADD:    w_alu_res = w_op_a + w_op_b;
      ALU_SUB:    w_alu_res = w_op_a - w_op_b;
      ALU_SLL:    w_alu_res = w_op_a << w_op_b[4:0];
      ALU_SLT:    w_alu_res = {31'b0, $signed(w_op_a) < $signed(w_op_b)};
      ALU_SLTU:   w_alu_res = {31'b0, w_op_a < w_op_b};
      ALU_XOR:    w_alu_res = w_op_a ^ w_op_b;
      ALU_SRL:    w_alu_res = w_op_a >> w_op_b[4:0];
      ALU_SRA:    w_alu_res = 32'($signed(w_op_a) >>> w_op_b[4:0]);
      ALU_OR:     w_alu_res = w_op_a | w_op_b;
      ALU_AND:    w_alu_res = w_op_a & w_op_b;
`ifdef RISCV_MUL_EN
      ALU_MUL:    w_alu_res = w_prod[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  w_alu_res = w_prod[63:32];
`endif
      default:    w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_br_taken = 1'b0;
    case (w_funct3)
      F3_BEQ:  w_br_taken = (w_rs1_data == w_rs2_data);
      F3_BNE:  w_br_taken = (w_rs1_data != w_rs2_data);
      F3_BLT:  w_br_taken = ($signed(w_rs1_data) < $signed(w_rs2_data));
      F3_BGE:  w_br_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
      F3_BLTU: w_br_taken = (w_rs1_data < w_rs2_data);
      F3_BGEU: w_br_taken = (w_rs1_data >= w_rs2_data);
      default: w_br_taken = 1'b0;
    endcase
  end

  assign w_pc4 = w_pc + 32'd4;

  always_comb begin
    w_next_pc = w_pc4;
    if (w_is_jal)                       w_next_pc = w_pc + w_imm;
    else if (w_is_jalr)                 w_next_pc = (w_rs1_data + w_imm) & ~32'd1;
    else if (w_is_branch && w_br_taken) w_next_pc = w_pc + w_imm;
  end

  always_comb begin
    case (w_wb_sel)
      WB_MEM:  w_rd_data = mem_read_data;
      WB_PC4:  w_rd_data = w_pc4;
      default: w_rd_data = w_alu_res;
    endcase
  end

  assign instr_addr       = w_pc;
  assign data_addr        = w_rs1_data + w_imm;
  assign mem_write_data   = w_rs2_data;
  assign should_read_mem  = w_is_load & ~reset;
  assign should_write_mem = w_is_store & ~reset;

endmodule

// File: tb/tb_riscv_core.sv
// Directed self-checking bench for riscv_core with behavioural instruction/data memories.
module tb_riscv_core;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [31:0] mem_read_data;
  logic [31:0] instr_addr;
  logic [31:0] data_addr;
  logic        should_read_mem;
  logic        should_write_mem;
  logic [31:0] mem_write_data;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];

  int n_checks = 0;
  int n_errors = 0;

  riscv_core dut (
    .clk              (clk),
    .reset            (reset),
    .instr            (instr),
    .mem_read_data    (mem_read_data),
    .instr_addr       (instr_addr),
    .data_addr        (data_addr),
    .should_read_mem  (should_read_mem),
    .should_write_mem (should_write_mem),
    .mem_write_data   (mem_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr         = imem[instr_addr[7:2]];
  assign mem_read_data = dmem[data_addr[7:2]];

  always @(posedge clk) begin
    if (should_write_mem) dmem[data_addr[7:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rf(input int idx);
    return dut.u_regfile.r_regs[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
  endtask

  logic [31:0] exp_mul;
  logic [31:0] exp_mulhu;
  int          nonzero;

  initial begin
    reset = 1'b1;
    clear_imem();
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    imem[0] = 32'h00306293; // ori  t0,x0,3
    imem[1] = 32'h00428313; // addi t1,t0,4
    imem[2] = 32'h0062A2A3; // sw   t1,5(t0)
    imem[3] = 32'h0052A383; // lw   t2,5(t0)
    imem[4] = 32'hFE7308E3; // beq  t1,t2,-16
    #12;
    check("reset_pc", instr_addr, 32'h0);
    check("reset_wr", {31'b0, should_write_mem}, 32'h0);
    check("reset_rd", {31'b0, should_read_mem}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    tick();
    check("ori_t0", rf(5), 32'd3);
    check("pc_after_ori", instr_addr, 32'h4);
    tick();
    check("addi_t1", rf(6), 32'd7);
    check("sw_wr", {31'b0, should_write_mem}, 32'h1);
    check("sw_rd", {31'b0, should_read_mem}, 32'h0);
    check("sw_addr", data_addr, 32'h8);
    check("sw_data", mem_write_data, 32'h7);
    tick();
    check("dmem_word", dmem[2], 32'h7);
    check("lw_rd", {31'b0, should_read_mem}, 32'h1);
    check("lw_wr", {31'b0, should_write_mem}, 32'h0);
    check("lw_addr", data_addr, 32'h8);
    tick();
    check("lw_t2", rf(7), 32'd7);
    check("pc_at_beq", instr_addr, 32'h10);
    tick();
    check("beq_taken_pc", instr_addr, 32'h0);

    // Run back to the store, then reset asynchronously mid-cycle.
    tick();
    tick();
    check("pc_at_sw", instr_addr, 32'h8);
    check("sw_again_wr", {31'b0, should_write_mem}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_wr_drop", {31'b0, should_write_mem}, 32'h0);
    check("async_rd_drop", {31'b0, should_read_mem}, 32'h0);
    check("async_pc", instr_addr, 32'h0);

    clear_imem();
    imem[0]  = 32'h800002B7; // lui  t0,0x80000
    imem[1]  = 32'h4042D313; // srai t1,t0,4
    imem[2]  = 32'h0042D393; // srli t2,t0,4
    imem[3]  = 32'h00500013; // addi x0,x0,5
    imem[4]  = 32'h008000EF; // jal  ra,+8
    imem[5]  = 32'h00100093; // addi ra,x0,1 (skipped)
    imem[6]  = 32'h000002B3; // add  t0,x0,x0
    imem[7]  = 32'h02100067; // jalr x0,0x21(x0)
    imem[8]  = 32'hFFD00293; // addi t0,x0,-3
    imem[9]  = 32'h00500313; // addi t1,x0,5
    imem[10] = 32'h026283B3; // mul  t2,t0,t1
    imem[11] = 32'h0262BE33; // mulhu t3,t0,t1
    imem[12] = 32'h40530EB3; // sub  t4,t1,t0
    imem[13] = 32'h0062AF33; // slt  t5,t0,t1
    imem[14] = 32'h00533FB3; // sltu t6,t1,t0
    imem[15] = 32'h0000006F; // jal  x0,0
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    nonzero = 0;
    for (int i = 0; i < 32; i++) if (rf(i) != 32'h0) nonzero++;
    check("regs_cleared", 32'(nonzero), 32'h0);
    check("pc_after_release", instr_addr, 32'h0);

    tick();
    check("lui_t0", rf(5), 32'h8000_0000);
    tick();
    check("srai_t1", rf(6), 32'hF800_0000);
    tick();
    check("srli_t2", rf(7), 32'h0800_0000);
    tick();
    check("x0_zero", rf(0), 32'h0);
    tick();
    check("jal_ra", rf(1), 32'h14);
    check("jal_pc", instr_addr, 32'h18);
    tick();
    check("add_x0_t0", rf(5), 32'h0);
    tick();
    check("jalr_pc", instr_addr, 32'h20);
    tick();
    tick();
    check("addi_neg", rf(5), 32'hFFFF_FFFD);
`ifdef RISCV_MUL_EN
    exp_mul   = 32'hFFFF_FFF1;
    exp_mulhu = 32'h0000_0004;
`else
    exp_mul   = 32'h0800_0000;
    exp_mulhu = 32'h0000_0000;
`endif
    tick();
    check("mul_t2", rf(7), exp_mul);
    tick();
    check("mulhu_t3", rf(28), exp_mulhu);
    tick();
    check("sub_t4", rf(29), 32'd8);
    tick();
    check("slt_t5", rf(30), 32'd1);
    tick();
    check("sltu_t6", rf(31), 32'd1);
    tick();
    tick();
    check("spin_pc", instr_addr, 32'h3C);
    check("ra_kept", rf(1), 32'h14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
